time_of_day_counter: RTL
========================

# time_of_day_counter

Consumes the free-running 1 Hz square wave produced by the clock divider and turns it into a BCD hours:minutes:seconds time-of-day in the 50 MHz domain. It treats the 1 Hz signal as an asynchronous input, synchronises it and edge-detects it. Each rising edge advances a cascaded 60/60/24 BCD counter. It also emits a one-cycle day-rollover pulse for the downstream date logic and accepts validated time loads from the setting/UI logic.

## Interface
- SYNC_STAGES, 2, number of flip-flops in the 1 Hz input synchroniser (legal 2..4)
- clk_50MHz  input  1  system clock, 50 MHz
- rst_n  input  1  reset, asynchronous, active-low; clock clk_50MHz
- clk_1hz_in  input  1  1 Hz square wave, treated as asynchronous to clk_50MHz
- hold  input  1  level; while high, seconds edges are discarded (time frozen)
- set_strobe  input  1  one-cycle load request
- set_hour_bcd  input  8  load value, hours, two BCD digits
- set_min_bcd  input  8  load value, minutes, two BCD digits
- set_sec_bcd  input  8  load value, seconds, two BCD digits
- hour_bcd  output  8  current hours 00..23, BCD
- min_bcd  output  8  current minutes 00..59, BCD
- sec_bcd  output  8  current seconds 00..59, BCD
- sec_tick  output  1  one-cycle pulse on each counted second
- day_carry  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
- set_err  output  1  one-cycle pulse when a set_strobe is rejected

## Operation
- Synchroniser: SYNC_STAGES flops plus one history flop. Reset clears all of them to 0. A rising edge is detected when the last sync stage is 1 and the history flop is 0. A falling edge is ignored.
- Counted edge: a detected rising edge with hold=0 and set_strobe=0.
- On a counted edge:
  - sec increments.
  - At 59, sec wraps to 00 and min increments.
  - At min 59, min wraps to 00 and hour increments.
  - At hour 23, hour wraps to 00.
- BCD arithmetic: the low digit wraps 9 -> 0 with a carry into the high digit. The terminal value for sec and min is 0x59; the terminal value for hour is 0x23. No binary intermediate is used.
- Load validation: every nibble must be <= 9, sec <= 0x59, min <= 0x59, hour <= 0x23.
- Valid load: all three fields are loaded on the next edge.
- Invalid load: registers are unchanged and set_err pulses.
- Load and edge in the same cycle: the load wins. The edge is dropped, sec_tick=0 and day_carry=0. If the load is invalid, the edge is still dropped.
- hold: a load is accepted while hold is high. An edge arriving while hold is high is lost, not deferred.
- Reset mid-operation: time returns to 00:00:00 immediately (asynchronously) and all pulses drop. Until the synchroniser history refills, a high clk_1hz_in is seen as a fresh rising edge; this is accepted behaviour.

## Timing
- Reset values: hour_bcd=0x00, min_bcd=0x00, sec_bcd=0x00, sec_tick=0, day_carry=0, set_err=0.
- Edge latency: clk_1hz_in rises and is captured by sync stage 1 at clock edge N. The counter registers update and sec_tick asserts at edge N+SYNC_STAGES. sec_tick is high in the same cycle the new value appears.
- day_carry asserts in the same cycle as the sec_tick that produces 00:00:00.
- Load latency: with set_strobe high at edge N, the outputs show the loaded value (or set_err=1) after edge N.
- All outputs are registered. No combinational path from any input to any output.
- Minimum counted-edge spacing: SYNC_STAGES+1 cycles; the 1 Hz source exceeds this by about 10^7.

## Structure
- Shared package `clock_pkg`, holding:
  - BCD limit constants: SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23.
  - A bcd_time struct {hour, min, sec}, each field 8 bits.
  - A function is_valid_bcd_time().
- Sub-module `bcd_mod_counter`, instantiated three times:
  - Two-digit BCD counter with inputs inc, load, load_val and parameter MAX.
  - Outputs value and wrap. wrap is combinational: (value==MAX)&&inc.
  - The seconds wrap output drives the minutes inc; the minutes wrap output drives the hours inc.
- Synchroniser and edge detect live in the top level.

## Test plan
- Reset, then 3 rising edges on clk_1hz_in (period 40 cycles) -> sec_bcd 0x01, 0x02, 0x03; each sec_tick exactly 1 cycle, SYNC_STAGES cycles after input capture.
- Load 23:59:58, then 2 edges -> 23:59:59, then 00:00:00 with day_carry=1 for one cycle, coincident with sec_tick.
- Load 09:59:59, then 1 edge -> 10:00:00. Load 00:09:09, then 1 edge -> 00:09:10 (digit carries).
- set_strobe with 24:00:00, then 12:5A:00, then 12:60:00 -> set_err pulses each time; time is unchanged.
- set_strobe 12:00:00 in the same cycle as a detected edge -> 12:00:00 and sec_tick=0. hold=1 across 5 edges -> time frozen, no sec_tick. hold=0, then next edge -> +1 s.
- Assert rst_n low mid-count at 14:33:07 -> all outputs are 0 immediately. Release -> counting resumes from 00:00:00.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day definitions: BCD field limits, the h:m:s record and load validation.
package clock_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } bcd_time;

  // A load is legal only if every nibble is a decimal digit and each field is in range.
  function automatic logic is_valid_bcd_time(bcd_time t);
    return (t.hour[7:4] <= 4'd9) && (t.hour[3:0] <= 4'd9) &&
           (t.min[7:4]  <= 4'd9) && (t.min[3:0]  <= 4'd9) &&
           (t.sec[7:4]  <= 4'd9) && (t.sec[3:0]  <= 4'd9) &&
           (t.hour <= HOUR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with parallel load; wrap flags the MAX -> 00 step.
module bcd_mod_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_nxt;

  always_comb begin
    value_nxt = value;
    if (load) begin
      value_nxt = load_val;
    end else if (inc) begin
      if (value == MAX)
        value_nxt = 8'h00;
      else if (value[3:0] == 4'd9)
        value_nxt = {value[7:4] + 4'd1, 4'd0};
      else
        value_nxt = {value[7:4], value[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) value <= 8'h00;
    else        value <= value_nxt;
  end

  assign wrap = (value == MAX) && inc;

endmodule

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time-of-day driven by a synchronised, edge-detected 1 Hz input.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       clk_1hz_in,
  input  logic       hold,
  input  logic       set_strobe,
  input  logic [7:0] set_hour_bcd,
  input  logic [7:0] set_min_bcd,
  input  logic [7:0] set_sec_bcd,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_tick,
  output logic       day_carry,
  output logic       set_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic                   count;
  logic                   set_valid;
  logic                   load_ok;
  logic                   sec_wrap;
  logic                   min_wrap;
  logic                   hour_wrap;
  bcd_time                set_time;

  // Synchroniser stages plus history flop for rising-edge detection
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_1hz_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign set_time  = '{hour: set_hour_bcd, min: set_min_bcd, sec: set_sec_bcd};
  assign set_valid = is_valid_bcd_time(set_time);
  assign load_ok   = set_strobe & set_valid;
  // A strobe, valid or not, swallows a coincident edge
  assign count     = rise & ~hold & ~set_strobe;

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .inc       (count),
    .load      (load_ok),
    .load_val  (set_sec_bcd),
    .value     (sec_bcd),
    .wrap      (sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .inc       (sec_wrap),
    .load      (load_ok),
    .load_val  (set_min_bcd),
    .value     (min_bcd),
    .wrap      (min_wrap)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .inc       (min_wrap),
    .load      (load_ok),
    .load_val  (set_hour_bcd),
    .value     (hour_bcd),
    .wrap      (hour_wrap)
  );

  // Status pulses registered alongside the counter update
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sec_tick  <= 1'b0;
      day_carry <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_tick  <= count;
      day_carry <= hour_wrap;
      set_err   <= set_strobe & ~set_valid;
    end
  end

endmodule
